// File: rtl/swc_alloc_pkg.sv
// Shared types and helpers for the multiport page allocator.
package swc_alloc_pkg;

  typedef enum logic [1:0] {
    OP_ALLOC,
    OP_FREE,
    OP_FORCE_FREE,
    OP_SET_USECNT
  } t_alloc_op;

  typedef enum logic [1:0] {
    S_INIT,
    S_IDLE,
    S_READ,
    S_EXEC
  } t_alloc_state;

  // cmd = {set_usecnt, force_free, free, alloc}; alloc wins, set_usecnt loses
  function automatic t_alloc_op f_prio_op(input logic [3:0] cmd);
    if (cmd[0])      return OP_ALLOC;
    else if (cmd[1]) return OP_FREE;
    else if (cmd[2]) return OP_FORCE_FREE;
    else             return OP_SET_USECNT;
  endfunction

endpackage

// File: rtl/swc_alloc_rr_arbiter.sv
// Round-robin arbiter: one-hot grant, search starts after the last grantee.
module swc_alloc_rr_arbiter #(
  parameter int g_num_ports = 7,
  parameter int g_idx_width = (g_num_ports > 1) ? $clog2(g_num_ports) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [g_num_ports-1:0] req,
  output logic [g_num_ports-1:0] grant,
  output logic [g_idx_width-1:0] grant_idx
);

  logic [g_idx_width-1:0] ptr;
  logic                   found;

  always_comb begin
    int unsigned idx;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    for (int unsigned i = 0; i < g_num_ports; i++) begin
      idx = (32'(ptr) + i) % g_num_ports;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = g_idx_width'(idx);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (en && found) begin
      ptr <= (grant_idx == g_idx_width'(g_num_ports - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/swc_multiport_page_allocator.sv
// Multiport page allocator: RR-arbitrated 3-stage engine over a free-page FIFO and use-count RAM.
// Define SWC_ALLOC_ERR_CHECK_EN to add the allocated-flag RAM and the sticky error_o check.
module swc_multiport_page_allocator
  import swc_alloc_pkg::*;
#(
  parameter int g_num_pages       = 1024,
  parameter int g_page_addr_width = 10,
  parameter int g_num_ports       = 7,
  parameter int g_usecount_width  = 4
) (
  input  logic                                      clk_i,
  input  logic                                      rst_i,
  input  logic [g_num_ports-1:0]                    alloc_i,
  input  logic [g_num_ports-1:0]                    free_i,
  input  logic [g_num_ports-1:0]                    force_free_i,
  input  logic [g_num_ports-1:0]                    set_usecnt_i,
  input  logic [g_num_ports*g_usecount_width-1:0]   usecnt_i,
  input  logic [g_num_ports*g_page_addr_width-1:0]  pgaddr_i,
  output logic [g_num_ports-1:0]                    done_o,
  output logic [g_page_addr_width-1:0]              pgaddr_o,
  output logic [g_num_ports-1:0]                    free_last_usecnt_o,
  output logic                                      nomem_o,
  output logic [g_page_addr_width:0]                free_pages_o,
  output logic                                      error_o
);

  localparam int AW = g_page_addr_width;
  localparam int UW = g_usecount_width;
  localparam int NP = g_num_ports;
  localparam int IW = (NP > 1) ? $clog2(NP) : 1;
  localparam logic [AW-1:0] LAST_PAGE = AW'(g_num_pages - 1);
  localparam logic [AW:0]   POOL_SIZE = (AW+1)'(g_num_pages);

  t_alloc_state  state;
  t_alloc_op     lat_op, g_op;
  logic [IW-1:0] lat_port, grant_idx;
  logic [AW-1:0] lat_addr, lat_page, g_addr, rd_addr;
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0]   count;
  logic [UW-1:0] lat_ucnt, g_ucnt, rd_cnt;
  logic [NP-1:0] req, grant;

  logic [AW-1:0] fifo_mem [g_num_pages];
  logic [UW-1:0] ucnt_ram [g_num_pages];

  logic          fifo_we, cnt_we, do_push, do_pop, want_push;
  logic [AW-1:0] fifo_wa, fifo_wd, cnt_wa;
  logic [UW-1:0] cnt_wd;

`ifdef SWC_ALLOC_ERR_CHECK_EN
  logic alloc_flag [g_num_pages];
  logic flag_we, flag_wd, rd_flag, err_set, error_q;
  assign error_o = error_q;
`else
  assign error_o = 1'b0;
`endif

  function automatic logic [AW-1:0] f_next(input logic [AW-1:0] p);
    return (p == LAST_PAGE) ? '0 : p + 1'b1;
  endfunction

  assign free_pages_o = count;
  assign nomem_o      = (state == S_INIT) || (count == '0);
  assign rd_addr      = (lat_op == OP_ALLOC) ? fifo_mem[rd_ptr] : lat_addr;

  // A port whose done_o is still high may not have dropped its request yet; mask it for that cycle.
  always_comb begin
    req = '0;
    for (int unsigned p = 0; p < NP; p++) begin
      req[p] = !done_o[p]
             && (alloc_i[p] || free_i[p] || force_free_i[p] || set_usecnt_i[p])
             && (f_prio_op({set_usecnt_i[p], force_free_i[p], free_i[p], alloc_i[p]}) != OP_ALLOC
                 || count != '0);
    end
  end

  always_comb begin
    g_op   = OP_ALLOC;
    g_addr = '0;
    g_ucnt = '0;
    for (int unsigned p = 0; p < NP; p++) begin
      if (grant[p]) begin
        g_op   = f_prio_op({set_usecnt_i[p], force_free_i[p], free_i[p], alloc_i[p]});
        g_addr = pgaddr_i[p*AW +: AW];
        g_ucnt = usecnt_i[p*UW +: UW];
      end
    end
  end

  swc_alloc_rr_arbiter #(
    .g_num_ports (NP),
    .g_idx_width (IW)
  ) u_arb (
    .clk       (clk_i),
    .rst       (rst_i),
    .en        (state == S_IDLE),
    .req       (req),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  always_comb begin
    fifo_we   = 1'b0;
    fifo_wa   = wr_ptr;
    fifo_wd   = lat_page;
    cnt_we    = 1'b0;
    cnt_wa    = lat_page;
    cnt_wd    = '0;
    do_push   = 1'b0;
    do_pop    = 1'b0;
    want_push = 1'b0;
`ifdef SWC_ALLOC_ERR_CHECK_EN
    flag_we   = 1'b0;
    flag_wd   = 1'b0;
    err_set   = 1'b0;
`endif
    case (state)
      S_INIT: begin
        fifo_we = 1'b1;
        fifo_wd = wr_ptr;
        cnt_we  = 1'b1;
        cnt_wa  = wr_ptr;
`ifdef SWC_ALLOC_ERR_CHECK_EN
        flag_we = 1'b1;
`endif
      end
      S_EXEC: begin
        case (lat_op)
          OP_ALLOC: begin
            do_pop = 1'b1;
            cnt_we = 1'b1;
            cnt_wd = lat_ucnt;
          end
          OP_FREE: begin
            if (rd_cnt == UW'(1)) begin
              want_push = 1'b1;
            end else if (rd_cnt != '0) begin
              cnt_we = 1'b1;
              cnt_wd = rd_cnt - UW'(1);
            end
          end
          OP_FORCE_FREE: want_push = 1'b1;
          default: begin
            cnt_we = 1'b1;
            cnt_wd = lat_ucnt;
          end
        endcase
`ifdef SWC_ALLOC_ERR_CHECK_EN
        if (lat_op == OP_ALLOC) begin
          flag_we = 1'b1;
          flag_wd = 1'b1;
        end else if (!rd_flag || (want_push && count == POOL_SIZE)) begin
          err_set   = 1'b1;
          cnt_we    = 1'b0;
          want_push = 1'b0;
        end else if (want_push) begin
          flag_we = 1'b1;
        end
`endif
        if (want_push) begin
          cnt_we  = 1'b1;
          cnt_wd  = '0;
          do_push = (count != POOL_SIZE);
          fifo_we = do_push;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (fifo_we) fifo_mem[fifo_wa] <= fifo_wd;
    if (cnt_we)  ucnt_ram[cnt_wa]  <= cnt_wd;
    if (state == S_READ) rd_cnt <= ucnt_ram[rd_addr];
`ifdef SWC_ALLOC_ERR_CHECK_EN
    if (flag_we) alloc_flag[cnt_wa] <= flag_wd;
    if (state == S_READ) rd_flag <= alloc_flag[rd_addr];
`endif
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state              <= S_INIT;
      rd_ptr             <= '0;
      wr_ptr             <= '0;
      count              <= '0;
      lat_op             <= OP_ALLOC;
      lat_port           <= '0;
      lat_addr           <= '0;
      lat_page           <= '0;
      lat_ucnt           <= '0;
      done_o             <= '0;
      pgaddr_o           <= '0;
      free_last_usecnt_o <= '0;
`ifdef SWC_ALLOC_ERR_CHECK_EN
      error_q            <= 1'b0;
`endif
    end else begin
      done_o             <= '0;
      free_last_usecnt_o <= '0;
      case (state)
        S_INIT: begin
          wr_ptr <= f_next(wr_ptr);
          count  <= count + 1'b1;
          if (wr_ptr == LAST_PAGE) state <= S_IDLE;
        end
        S_IDLE: begin
          if (grant != '0) begin
            lat_port <= grant_idx;
            lat_op   <= g_op;
            lat_addr <= g_addr;
            lat_ucnt <= g_ucnt;
            state    <= S_READ;
          end
        end
        S_READ: begin
          lat_page <= rd_addr;
          state    <= S_EXEC;
        end
        S_EXEC: begin
          done_o[lat_port] <= 1'b1;
          if (do_pop) begin
            rd_ptr   <= f_next(rd_ptr);
            count    <= count - 1'b1;
            pgaddr_o <= lat_page;
          end
          if (do_push) begin
            wr_ptr                       <= f_next(wr_ptr);
            count                        <= count + 1'b1;
            free_last_usecnt_o[lat_port] <= 1'b1;
          end
`ifdef SWC_ALLOC_ERR_CHECK_EN
          if (err_set) error_q <= 1'b1;
`endif
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_swc_multiport_page_allocator.sv
// Directed bench for swc_multiport_page_allocator (7 ports, 1024 pages, 4-bit use counts).
module tb_swc_multiport_page_allocator;

  localparam int NP = 7;
  localparam int AW = 10;
  localparam int UW = 4;
`ifdef SWC_ALLOC_ERR_CHECK_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [NP-1:0]    alloc = '0, fr = '0, ff = '0, su = '0;
  logic [NP*UW-1:0] usecnt = '0;
  logic [NP*AW-1:0] pgaddr = '0;
  logic [NP-1:0]    done, last;
  logic [AW-1:0]    pga_o;
  logic             nomem, err;
  logic [AW:0]      fpages;

  int total = 0;
  int bad   = 0;
  int last_port = 0;

  always #5 clk = ~clk;

  swc_multiport_page_allocator #(
    .g_num_pages       (1024),
    .g_page_addr_width (AW),
    .g_num_ports       (NP),
    .g_usecount_width  (UW)
  ) dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .alloc_i            (alloc),
    .free_i             (fr),
    .force_free_i       (ff),
    .set_usecnt_i       (su),
    .usecnt_i           (usecnt),
    .pgaddr_i           (pgaddr),
    .done_o             (done),
    .pgaddr_o           (pga_o),
    .free_last_usecnt_o (last),
    .nomem_o            (nomem),
    .free_pages_o       (fpages),
    .error_o            (err)
  );

  // op: 0 alloc, 1 free, 2 force_free, 3 set_usecnt
  task automatic port_cmd(input int p, input int op, input int addr, input int uc,
                          output int page, output int cyc, output bit lastf, output bit ok);
    logic [AW-1:0] a;
    logic [UW-1:0] u;
    a = addr[AW-1:0];
    u = uc[UW-1:0];
    usecnt[p*UW +: UW] = u;
    pgaddr[p*AW +: AW] = a;
    case (op)
      0: alloc[p] = 1'b1;
      1: fr[p]    = 1'b1;
      2: ff[p]    = 1'b1;
      default: su[p] = 1'b1;
    endcase
    page = 0; cyc = 0; lastf = 1'b0; ok = 1'b0;
    while (!ok && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (done[p]) begin
        ok = 1'b1;
        page = int'(pga_o);
        lastf = last[p];
      end
    end
    alloc[p] = 1'b0; fr[p] = 1'b0; ff[p] = 1'b0; su[p] = 1'b0;
  endtask

  task automatic do_init(output int n, output bit saw_done);
    n = 0; saw_done = 1'b0;
    rst = 1'b0;
    while (nomem && n < 2000) begin
      @(negedge clk);
      n++;
      if (done != '0) saw_done = 1'b1;
    end
  endtask

  task automatic test_reset;
    int n; bit sd;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (done !== '0)     begin bad++; $display("FAIL reset_done: got %h want 0", done); end
    total++; if (nomem !== 1'b1)  begin bad++; $display("FAIL reset_nomem: got %b want 1", nomem); end
    total++; if (fpages !== '0)   begin bad++; $display("FAIL reset_free_pages: got %0d want 0", fpages); end
    total++; if (err !== 1'b0)    begin bad++; $display("FAIL reset_error: got %b want 0", err); end
    total++; if (pga_o !== '0)    begin bad++; $display("FAIL reset_pgaddr: got %0d want 0", pga_o); end
    do_init(n, sd);
    total++; if (n !== 1024)      begin bad++; $display("FAIL init_cycles: got %0d want 1024", n); end
    total++; if (fpages !== 1024) begin bad++; $display("FAIL init_free_pages: got %0d want 1024", fpages); end
    total++; if (nomem !== 1'b0)  begin bad++; $display("FAIL init_nomem: got %b want 0", nomem); end
  endtask

  task automatic test_basic_alloc;
    int pg, cyc; bit lf, ok;
    port_cmd(0, 0, 0, 2, pg, cyc, lf, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL alloc0_timeout: got %b want 1", ok); end
    total++; if (pg !== 0)    begin bad++; $display("FAIL alloc0_page: got %0d want 0", pg); end
    total++; if (cyc !== 3)   begin bad++; $display("FAIL alloc0_latency: got %0d want 3", cyc); end
    port_cmd(0, 0, 0, 2, pg, cyc, lf, ok);
    total++; if (pg !== 1)    begin bad++; $display("FAIL alloc1_page: got %0d want 1", pg); end
    total++; if (fpages !== 1022) begin bad++; $display("FAIL alloc_free_pages: got %0d want 1022", fpages); end
    port_cmd(0, 1, 0, 0, pg, cyc, lf, ok);
    total++; if (lf !== 1'b0) begin bad++; $display("FAIL free1_last: got %b want 0", lf); end
    total++; if (fpages !== 1022) begin bad++; $display("FAIL free1_free_pages: got %0d want 1022", fpages); end
    port_cmd(0, 1, 0, 0, pg, cyc, lf, ok);
    total++; if (lf !== 1'b1) begin bad++; $display("FAIL free2_last: got %b want 1", lf); end
    total++; if (fpages !== 1023) begin bad++; $display("FAIL free2_free_pages: got %0d want 1023", fpages); end
    last_port = 0;
  endtask

  task automatic test_fairness;
    int sp[14], spg[14], st[14];
    int cnt, n, start;
    start = (last_port + 1) % NP;
    for (int p = 0; p < NP; p++) usecnt[p*UW +: UW] = 4'd1;
    alloc = '1;
    cnt = 0; n = 0;
    while (cnt < 14 && n < 300) begin
      @(negedge clk);
      n++;
      if (done != '0) begin
        total++; if (!$onehot(done)) begin bad++; $display("FAIL fair_onehot: got %b want one-hot", done); end
        for (int p = 0; p < NP; p++) if (done[p]) sp[cnt] = p;
        spg[cnt] = int'(pga_o);
        st[cnt] = n;
        cnt++;
      end
    end
    alloc = '0;
    total++; if (cnt !== 14) begin bad++; $display("FAIL fair_count: got %0d want 14", cnt); end
    for (int i = 0; i < cnt; i++) begin
      total++; if (sp[i] !== (start + i) % NP) begin bad++; $display("FAIL fair_port[%0d]: got %0d want %0d", i, sp[i], (start + i) % NP); end
      total++; if (spg[i] !== 2 + i) begin bad++; $display("FAIL fair_page[%0d]: got %0d want %0d", i, spg[i], 2 + i); end
      if (i > 0) begin
        total++; if (st[i] - st[i-1] !== 3) begin bad++; $display("FAIL fair_gap[%0d]: got %0d want 3", i, st[i] - st[i-1]); end
      end
    end
    if (cnt == 14) begin
      total++; if (st[7] - st[0] !== 21) begin bad++; $display("FAIL fair_period: got %0d want 21", st[7] - st[0]); end
    end
    total++; if (fpages !== 1009) begin bad++; $display("FAIL fair_free_pages: got %0d want 1009", fpages); end
    last_port = (start + 13) % NP;
  endtask

  task automatic test_exhaustion;
    int pg, cyc, first, tmo, n, pg3;
    bit lf, ok, stalled_done, got3, got5, last5;
    int t3, t5;
    tmo = 0; first = -1;
    for (int i = 0; i < 1009; i++) begin
      port_cmd(3, 0, 0, 1, pg, cyc, lf, ok);
      if (!ok) tmo++;
      if (i == 0) first = pg;
    end
    total++; if (tmo !== 0)    begin bad++; $display("FAIL exh_timeouts: got %0d want 0", tmo); end
    total++; if (first !== 16) begin bad++; $display("FAIL exh_first_page: got %0d want 16", first); end
    total++; if (pg !== 0)     begin bad++; $display("FAIL exh_last_page: got %0d want 0", pg); end
    total++; if (fpages !== 0) begin bad++; $display("FAIL exh_free_pages: got %0d want 0", fpages); end
    total++; if (nomem !== 1'b1) begin bad++; $display("FAIL exh_nomem: got %b want 1", nomem); end
    usecnt[3*UW +: UW] = 4'd1;
    alloc[3] = 1'b1;
    stalled_done = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (done != '0) stalled_done = 1'b1;
    end
    total++; if (stalled_done !== 1'b0) begin bad++; $display("FAIL exh_stall: got done=%b want none", stalled_done); end
    pgaddr[5*AW +: AW] = 10'd17;
    ff[5] = 1'b1;
    got3 = 1'b0; got5 = 1'b0; last5 = 1'b0; pg3 = -1; t3 = 0; t5 = 0; n = 0;
    while (!(got3 && got5) && n < 100) begin
      @(negedge clk);
      n++;
      if (done[5]) begin got5 = 1'b1; last5 = last[5]; t5 = n; ff[5] = 1'b0; end
      if (done[3]) begin got3 = 1'b1; pg3 = int'(pga_o); t3 = n; alloc[3] = 1'b0; end
    end
    alloc[3] = 1'b0; ff[5] = 1'b0;
    total++; if ({got3, got5} !== 2'b11) begin bad++; $display("FAIL exh_both_done: got %b want 11", {got3, got5}); end
    total++; if (last5 !== 1'b1) begin bad++; $display("FAIL exh_ff_last: got %b want 1", last5); end
    total++; if (pg3 !== 17)     begin bad++; $display("FAIL exh_refill_page: got %0d want 17", pg3); end
    total++; if (!(t5 < t3))     begin bad++; $display("FAIL exh_order: got t5=%0d t3=%0d want t5<t3", t5, t3); end
    total++; if (fpages !== 0)   begin bad++; $display("FAIL exh_refill_free_pages: got %0d want 0", fpages); end
  endtask

  task automatic test_deferred_usecnt;
    int pg, cyc; bit lf, ok;
    port_cmd(1, 2, 2, 0, pg, cyc, lf, ok);
    total++; if (lf !== 1'b1)  begin bad++; $display("FAIL def_ff_last: got %b want 1", lf); end
    total++; if (fpages !== 1) begin bad++; $display("FAIL def_ff_free_pages: got %0d want 1", fpages); end
    port_cmd(2, 0, 0, 0, pg, cyc, lf, ok);
    total++; if (pg !== 2)     begin bad++; $display("FAIL def_alloc_page: got %0d want 2", pg); end
    port_cmd(2, 3, 2, 3, pg, cyc, lf, ok);
    total++; if (ok !== 1'b1)  begin bad++; $display("FAIL def_set_done: got %b want 1", ok); end
    total++; if (fpages !== 0) begin bad++; $display("FAIL def_set_free_pages: got %0d want 0", fpages); end
    for (int i = 0; i < 3; i++) begin
      port_cmd(2, 1, 2, 0, pg, cyc, lf, ok);
      total++; if (lf !== (i == 2)) begin bad++; $display("FAIL def_free%0d_last: got %b want %b", i, lf, (i == 2)); end
    end
    total++; if (fpages !== 1) begin bad++; $display("FAIL def_free_pages: got %0d want 1", fpages); end
    port_cmd(2, 1, 2, 0, pg, cyc, lf, ok);
    total++; if (ok !== 1'b1)  begin bad++; $display("FAIL def_free4_done: got %b want 1", ok); end
    total++; if (lf !== 1'b0)  begin bad++; $display("FAIL def_free4_last: got %b want 0", lf); end
    total++; if (fpages !== 1) begin bad++; $display("FAIL def_free4_free_pages: got %0d want 1", fpages); end
    total++; if (err !== ERR_EN) begin bad++; $display("FAIL def_error: got %b want %b", err, ERR_EN); end
  endtask

  task automatic test_reset_mid;
    int n; bit sd;
    usecnt[4*UW +: UW] = 4'd1;
    alloc[4] = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    #1;
    total++; if (done !== '0)   begin bad++; $display("FAIL rstmid_done: got %h want 0", done); end
    total++; if (fpages !== '0) begin bad++; $display("FAIL rstmid_free_pages: got %0d want 0", fpages); end
    total++; if (nomem !== 1'b1) begin bad++; $display("FAIL rstmid_nomem: got %b want 1", nomem); end
    @(negedge clk);
    alloc[4] = 1'b0;
    do_init(n, sd);
    total++; if (sd !== 1'b0)     begin bad++; $display("FAIL rstmid_spurious_done: got %b want 0", sd); end
    total++; if (n !== 1024)      begin bad++; $display("FAIL rstmid_init_cycles: got %0d want 1024", n); end
    total++; if (fpages !== 1024) begin bad++; $display("FAIL rstmid_free_pages_after: got %0d want 1024", fpages); end
    total++; if (err !== 1'b0)    begin bad++; $display("FAIL rstmid_error: got %b want 0", err); end
  endtask

  task automatic test_regression;
    int pgs[10], rem[10];
    int pg, cyc, p;
    bit lf, ok;
    for (int i = 0; i < 10; i++) begin
      p = $urandom_range(0, NP - 1);
      rem[i] = $urandom_range(1, 3);
      port_cmd(p, 0, 0, rem[i], pg, cyc, lf, ok);
      pgs[i] = pg;
      total++; if (pg !== i) begin bad++; $display("FAIL reg_alloc_page[%0d]: got %0d want %0d", i, pg, i); end
    end
    total++; if (fpages !== 1014) begin bad++; $display("FAIL reg_free_pages_mid: got %0d want 1014", fpages); end
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 10; i++) begin
        if (rem[i] > 0) begin
          p = $urandom_range(0, NP - 1);
          port_cmd(p, 1, pgs[i], 0, pg, cyc, lf, ok);
          total++; if (lf !== (rem[i] == 1)) begin bad++; $display("FAIL reg_free_last[%0d]: got %b want %b", i, lf, (rem[i] == 1)); end
          rem[i]--;
        end
      end
    end
    total++; if (fpages !== 1024) begin bad++; $display("FAIL reg_free_pages_end: got %0d want 1024", fpages); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset;
    test_basic_alloc;
    test_fairness;
    test_exhaustion;
    test_deferred_usecnt;
    test_reset_mid;
    test_regression;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
